opponent_state_decoder: RTL and testbench

Parses the 32-bit word stream from the Ethernet receive stage (`axiov`/`axiod`, `eth_refclk` domain) into validated opponent kart state: position, heading and game status. Its registered outputs drive the `opponent_x`, `opponent_y` and `direction` inputs of `track_view`, `racer_view` and `forward_view`, replacing their hard-wired constants. It also reports link health: a stale-link flag and error counters for the LEDs.

---
 rtl/kart_pkg.sv | 42 ++++
 rtl/sat_timer.sv | 41 ++++
 rtl/opponent_state_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_opponent_state_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kart_pkg.sv
// Shared kart link definitions: frame sync byte, game status encoding, word field
// positions and the frame checksum. The transmitter's frame packer and the
// opponent state decoder both build on this package so the wire format lives in
// one place.
package kart_pkg;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int unsigned DIR_MAX = 359;

  typedef enum logic [1:0] {
    StatIdle    = 2'd0,
    StatRacing  = 2'd1,
    StatWon     = 2'd2,
    StatLost    = 2'd3
  } game_stat_t;

  // w0: sync, sequence number, zero pad
  localparam int unsigned W0_SYNC_MSB = 31;
  localparam int unsigned W0_SYNC_LSB = 24;
  localparam int unsigned W0_SEQ_MSB  = 23;
  localparam int unsigned W0_SEQ_LSB  = 16;
  // w1: x, y, heading, zero pad
  localparam int unsigned W1_X_MSB    = 31;
  localparam int unsigned W1_X_LSB    = 21;
  localparam int unsigned W1_Y_MSB    = 20;
  localparam int unsigned W1_Y_LSB    = 10;
  localparam int unsigned W1_DIR_MSB  = 9;
  localparam int unsigned W1_DIR_LSB  = 1;
  // w2: game status, zero pad, checksum
  localparam int unsigned W2_STAT_MSB = 31;
  localparam int unsigned W2_STAT_LSB = 30;
  localparam int unsigned W2_CSUM_MSB = 15;
  localparam int unsigned W2_CSUM_LSB = 0;

  // Mod-2^16 sum of the four half-words of w0 and w1.
  function automatic logic [15:0] checksum16(input logic [31:0] w0, input logic [31:0] w1);
    logic [15:0] sum;
    sum = w0[31:16] + w0[15:0] + w1[31:16] + w1[15:0];
    return sum;
  endfunction

endpackage

// File: rtl/sat_timer.sv
// Saturating up-counter with synchronous clear.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset, counter to 0
//   clear_i  : counter to 0 on the next edge (wins over inc_i)
//   inc_i    : count up by one, holding at Max
//   at_max_o : counter currently equals Max
module sat_timer #(
  parameter int unsigned Max = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int unsigned Width = (Max > 0) ? $clog2(Max + 1) : 1;
  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/opponent_state_decoder.sv
// Decodes the 3-word opponent frame stream from the Ethernet receive stage into
// registered opponent kart state, and reports link health.
//   clk_in    : eth_refclk, the only clock
//   rst_in    : synchronous active-low reset
//   axiov     : one-cycle strobe per received word
//   axiod     : received 32-bit word
//   opp_x/y   : opponent position
//   opp_dir   : opponent heading, degrees 0..359
//   opp_stat  : opponent game status
//   opp_valid : sticky, set by the first committed frame
//   update    : one-cycle pulse on each commit
//   stale     : no commit for STALE_CYCLES cycles
//   err_count : rejected or timed-out frames, saturating at 255
module opponent_state_decoder
  import kart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned STALE_CYCLES   = 25_000_000,
  parameter logic [10:0] RESET_X        = 11'd320,
  parameter logic [10:0] RESET_Y        = 11'd320
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiov,
  input  logic [31:0] axiod,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [1:0]  opp_stat,
  output logic        opp_valid,
  output logic        update,
  output logic        stale,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StW1, StW2, StCheck} state_e;

  state_e      state_q, state_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] w1_q, w1_d;
  game_stat_t  stat_q, stat_d;
  logic        csum_ok_q, csum_ok_d;
  logic        commit_q, commit_d;
  logic        reject_q, reject_d;
  logic [7:0]  last_seq_q, last_seq_d;
  logic        seen_q, seen_d;
  logic [10:0] opp_x_q, opp_x_d;
  logic [10:0] opp_y_q, opp_y_d;
  logic [8:0]  opp_dir_q, opp_dir_d;
  game_stat_t  opp_stat_q, opp_stat_d;
  logic        opp_valid_q, opp_valid_d;
  logic        update_q, update_d;
  logic [7:0]  err_q, err_d;

  logic       in_frame;
  logic       to_at_max;
  logic       to_expired;
  logic       stale_at_max;
  logic [7:0] seq;
  logic [8:0] dir;
  logic       frame_ok;
  logic       err_inc;

  assign in_frame = (state_q == StW1) || (state_q == StW2);
  assign seq      = w0_q[W0_SEQ_MSB:W0_SEQ_LSB];
  assign dir      = w1_q[W1_DIR_MSB:W1_DIR_LSB];
  assign frame_ok = csum_ok_q && (dir <= 9'(DIR_MAX));

  // Counts idle cycles inside a frame. Reaching the limit with still no word
  // means this is idle cycle TIMEOUT_CYCLES+1, so exactly TIMEOUT_CYCLES passes.
  sat_timer #(
    .Max (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .clear_i  (!in_frame || axiov),
    .inc_i    (1'b1),
    .at_max_o (to_at_max)
  );

  assign to_expired = in_frame && !axiov && to_at_max;

  // Cleared on the same edge that raises update.
  sat_timer #(
    .Max (STALE_CYCLES)
  ) u_stale (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .clear_i  (commit_q),
    .inc_i    (1'b1),
    .at_max_o (stale_at_max)
  );

  always_comb begin
    state_d     = state_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    stat_d      = stat_q;
    csum_ok_d   = csum_ok_q;
    commit_d    = 1'b0;
    reject_d    = 1'b0;
    last_seq_d  = last_seq_q;
    seen_d      = seen_q;
    opp_x_d     = opp_x_q;
    opp_y_d     = opp_y_q;
    opp_dir_d   = opp_dir_q;
    opp_stat_d  = opp_stat_q;
    opp_valid_d = opp_valid_q;
    update_d    = 1'b0;
    err_d       = err_q;
    err_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (axiov && (axiod[W0_SYNC_MSB:W0_SYNC_LSB] == SYNC)) begin
          w0_d    = axiod;
          state_d = StW1;
        end
      end
      StW1: begin
        // No resync here: a word starting with SYNC is just data.
        if (axiov) begin
          w1_d    = axiod;
          state_d = StW2;
        end else if (to_expired) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end
      end
      StW2: begin
        if (axiov) begin
          stat_d    = game_stat_t'(axiod[W2_STAT_MSB:W2_STAT_LSB]);
          csum_ok_d = (checksum16(w0_q, w1_q) == axiod[W2_CSUM_MSB:W2_CSUM_LSB]);
          state_d   = StCheck;
        end else if (to_expired) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end
      end
      StCheck: begin
        // Duplicates are dropped without counting as errors.
        commit_d = frame_ok && (!seen_q || (seq != last_seq_q));
        reject_d = !frame_ok;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Apply stage. w0_q/w1_q cannot be overwritten yet: the next frame's w1 is
    // at least two edges away from here.
    if (commit_q) begin
      opp_x_d     = w1_q[W1_X_MSB:W1_X_LSB];
      opp_y_d     = w1_q[W1_Y_MSB:W1_Y_LSB];
      opp_dir_d   = dir;
      opp_stat_d  = stat_q;
      opp_valid_d = 1'b1;
      last_seq_d  = seq;
      seen_d      = 1'b1;
      update_d    = 1'b1;
    end

    // A reject (apply stage) and a timeout (mid-frame) never coincide.
    if ((reject_q || err_inc) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      w0_q        <= '0;
      w1_q        <= '0;
      stat_q      <= StatIdle;
      csum_ok_q   <= 1'b0;
      commit_q    <= 1'b0;
      reject_q    <= 1'b0;
      last_seq_q  <= '0;
      seen_q      <= 1'b0;
      opp_x_q     <= RESET_X;
      opp_y_q     <= RESET_Y;
      opp_dir_q   <= 9'd270;
      opp_stat_q  <= StatIdle;
      opp_valid_q <= 1'b0;
      update_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      stat_q      <= stat_d;
      csum_ok_q   <= csum_ok_d;
      commit_q    <= commit_d;
      reject_q    <= reject_d;
      last_seq_q  <= last_seq_d;
      seen_q      <= seen_d;
      opp_x_q     <= opp_x_d;
      opp_y_q     <= opp_y_d;
      opp_dir_q   <= opp_dir_d;
      opp_stat_q  <= opp_stat_d;
      opp_valid_q <= opp_valid_d;
      update_q    <= update_d;
      err_q       <= err_d;
    end
  end

  assign opp_x     = opp_x_q;
  assign opp_y     = opp_y_q;
  assign opp_dir   = opp_dir_q;
  assign opp_stat  = opp_stat_q;
  assign opp_valid = opp_valid_q;
  assign update    = update_q;
  assign stale     = stale_at_max;
  assign err_count = err_q;

endmodule

// File: tb/tb_opponent_state_decoder.sv
// Bench for opponent_state_decoder: directed scenarios plus randomized frames,
// checked against a frame-level model of the decoding rules.
module tb_opponent_state_decoder;

  localparam int unsigned StaleCycles   = 100;
  localparam int unsigned TimeoutCycles = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiov = 1'b0;
  logic [31:0] axiod = '0;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [1:0]  opp_stat;
  logic        opp_valid, update, stale;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  opponent_state_decoder #(
    .TIMEOUT_CYCLES (TimeoutCycles),
    .STALE_CYCLES   (StaleCycles),
    .RESET_X        (11'd320),
    .RESET_Y        (11'd320)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .axiov     (axiov),
    .axiod     (axiod),
    .opp_x     (opp_x),
    .opp_y     (opp_y),
    .opp_dir   (opp_dir),
    .opp_stat  (opp_stat),
    .opp_valid (opp_valid),
    .update    (update),
    .stale     (stale),
    .err_count (err_count)
  );

  // Reference state
  logic [10:0] m_x, m_y;
  logic [8:0]  m_dir;
  logic [1:0]  m_stat;
  logic        m_valid, m_seen;
  logic [7:0]  m_last;
  int          m_err;
  int          m_idle_since_commit;
  bit          commit_edge;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; keeps the cycles-since-commit model and checks stale.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || commit_edge) m_idle_since_commit = 0;
    else if (m_idle_since_commit < int'(StaleCycles)) m_idle_since_commit++;
    commit_edge = 1'b0;
    #1;
    check_eq("stale", 32'(stale), 32'(m_idle_since_commit == int'(StaleCycles)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      axiov = 1'b0;
      axiod = $urandom;
      tick();
      check_eq("no_update", 32'(update), 32'd0);
    end
  endtask

  task automatic drive(input logic [31:0] w);
    axiov = 1'b1;
    axiod = w;
    tick();
    axiov = 1'b0;
    axiod = $urandom;
  endtask

  task automatic model_reset();
    m_x = 11'd320; m_y = 11'd320; m_dir = 9'd270; m_stat = 2'd0;
    m_valid = 1'b0; m_seen = 1'b0; m_last = 8'd0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_x"}, 32'(opp_x), 32'(m_x));
    check_eq({tag, "_y"}, 32'(opp_y), 32'(m_y));
    check_eq({tag, "_dir"}, 32'(opp_dir), 32'(m_dir));
    check_eq({tag, "_stat"}, 32'(opp_stat), 32'(m_stat));
    check_eq({tag, "_valid"}, 32'(opp_valid), 32'(m_valid));
    check_eq({tag, "_err"}, 32'(err_count), 32'(m_err));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    axiov = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] make_w0(input logic [7:0] seq);
    return {8'hA5, seq, 16'h0000};
  endfunction

  function automatic logic [31:0] make_w1(input logic [10:0] x, input logic [10:0] y,
                                          input logic [8:0] dir);
    return {x, y, dir, 1'b0};
  endfunction

  function automatic logic [15:0] sum16(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(a[31:16]) + int'(a[15:0]) + int'(b[31:16]) + int'(b[15:0]);
    return 16'(s % 65536);
  endfunction

  // Sends one frame and checks the outcome on the three edges after w2.
  task automatic send_frame(input logic [7:0] seq, input logic [10:0] x, input logic [10:0] y,
                            input logic [8:0] dir, input logic [1:0] stat, input bit bad_csum,
                            input int gap1, input int gap2);
    logic [31:0] w0, w1;
    logic [15:0] cs;
    bit          commit, reject;
    w0 = make_w0(seq);
    w1 = make_w1(x, y, dir);
    cs = sum16(w0, w1);
    if (bad_csum) cs = cs ^ 16'h0001;
    drive(w0);
    idle(gap1);
    drive(w1);
    idle(gap2);
    drive({stat, 14'h0, cs});
    reject = bad_csum || (dir > 9'd359);
    commit = !reject && !(m_seen && (seq == m_last));
    check_eq("upd_n0", 32'(update), 32'd0);
    tick();
    check_eq("upd_n1", 32'(update), 32'd0);
    commit_edge = commit;
    tick();
    if (commit) begin
      m_x = x; m_y = y; m_dir = dir; m_stat = stat;
      m_valid = 1'b1; m_seen = 1'b1; m_last = seq;
    end
    if (reject && m_err < 255) m_err++;
    check_eq("upd_n2", 32'(update), 32'(commit));
    check_outputs("frame");
    tick();
    check_eq("upd_n3", 32'(update), 32'd0);
  endtask

  // w0 and w1, then an over-long gap before w2: abort on idle cycle 65.
  task automatic timeout_frame(input logic [7:0] seq);
    drive(make_w0(seq));
    drive(make_w1(11'd10, 11'd20, 9'd30));
    idle(TimeoutCycles);
    check_eq("to_pre_err", 32'(err_count), 32'(m_err));
    idle(1);
    if (m_err < 255) m_err++;
    check_eq("to_err", 32'(err_count), 32'(m_err));
  endtask

  function automatic logic [31:0] junk_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:24] == 8'hA5) w[31] = 1'b0;
    return w;
  endfunction

  function automatic int pick_gap();
    if ($urandom_range(0, 7) == 0) return int'(TimeoutCycles);
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [7:0] seq;
    int         kind;

    commit_edge = 1'b0;
    m_idle_since_commit = 0;
    model_reset();
    do_reset(2);
    check_outputs("reset");
    check_eq("reset_upd", 32'(update), 32'd0);

    // No traffic: stale rises on cycle 100.
    idle(99);
    check_eq("stale_pre", 32'(stale), 32'd0);
    idle(1);
    check_eq("stale_rise", 32'(stale), 32'd1);

    // Good frame, which also clears stale.
    send_frame(8'd1, 11'd191, 11'd200, 9'd90, 2'd1, 1'b0, 0, 0);
    check_eq("good_valid", 32'(opp_valid), 32'd1);

    // Bad checksum, then a good frame.
    send_frame(8'd2, 11'd5, 11'd6, 9'd7, 2'd2, 1'b1, 0, 0);
    send_frame(8'd3, 11'd100, 11'd101, 9'd180, 2'd3, 1'b0, 1, 1);

    // Heading range edge.
    send_frame(8'd4, 11'd50, 11'd60, 9'd360, 2'd1, 1'b0, 0, 0);
    send_frame(8'd4, 11'd51, 11'd61, 9'd359, 2'd1, 1'b0, 0, 0);

    // Duplicate sequence number.
    send_frame(8'd5, 11'd300, 11'd301, 9'd10, 2'd0, 1'b0, 0, 0);
    send_frame(8'd5, 11'd400, 11'd401, 9'd20, 2'd1, 1'b0, 0, 0);

    // Timeout boundary.
    timeout_frame(8'd6);
    send_frame(8'd7, 11'd700, 11'd701, 9'd100, 2'd2, 1'b0, 0, 0);
    send_frame(8'd8, 11'd800, 11'd801, 9'd200, 2'd1, 1'b0, 0, 64);
    send_frame(8'd9, 11'd900, 11'd901, 9'd300, 2'd1, 1'b0, 64, 0);

    // Reset mid-frame, then the last committed seq must be accepted again.
    drive(make_w0(8'd20));
    drive(make_w1(11'd1, 11'd2, 9'd3));
    do_reset(1);
    check_outputs("midrst");
    check_eq("midrst_upd", 32'(update), 32'd0);
    idle(2);
    send_frame(8'd9, 11'd123, 11'd456, 9'd45, 2'd3, 1'b0, 0, 0);

    // Randomized frames.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      seq = 8'($urandom);
      if (m_seen && seq == m_last) seq = seq + 8'd1;
      if (kind == 8 && m_seen) seq = m_last;
      if (kind == 9) begin
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) drive(junk_word());
        idle(1);
      end
      send_frame(seq, 11'($urandom), 11'($urandom),
                 (kind == 7) ? 9'($urandom_range(360, 511)) : 9'($urandom_range(0, 359)),
                 2'($urandom), kind == 6, pick_gap(), pick_gap());
      idle(int'($urandom_range(0, 3)));
    end

    // Drive the error counter into saturation.
    while (m_err < 255) begin
      send_frame(8'($urandom), 11'd1, 11'd1, 9'd1, 2'd0, 1'b1, 0, 0);
    end
    send_frame(8'd77, 11'd1, 11'd1, 9'd1, 2'd0, 1'b1, 0, 0);
    send_frame(8'd78, 11'd1, 11'd1, 9'd400, 2'd0, 1'b0, 0, 0);
    check_eq("err_sat", 32'(err_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
